// File: rtl/clk_div_int_if.sv
// clk_div_int_if: control and output bundle for the integer clock divider.
// The master side (rate decoder / bench) drives enable and ratio; the slave
// side (the divider) returns the divided clock and the period tick.
interface clk_div_int_if #(
  parameter int RATIO_WD = 8
);
  logic                clk_en;
  logic [RATIO_WD-1:0] div_ratio;
  logic                div_clk;
  logic                period_tick;

  modport master (
    output clk_en,
    output div_ratio,
    input  div_clk,
    input  period_tick
  );

  modport slave (
    input  clk_en,
    input  div_ratio,
    output div_clk,
    output period_tick
  );
endinterface

// File: rtl/clk_div_int.sv
// clk_div_int: integer clock divider producing the UART TX bit clock.
// Divides ref_clk by an 8-bit ratio N (even or odd). The high phase lasts
// N>>1 reference cycles and the low phase the remainder, so odd ratios get
// the extra cycle in the low phase. With the divider disabled or N < 2 the
// output is the reference clock itself and all state is held cleared.
//
// Optional feature, macro CLKDIV_RATIO_SHADOW_EN:
//   defined   - N comes from a shadow register that loads the ratio input
//               while in bypass and at each period boundary, so a ratio
//               change only takes effect once the current period completes.
//   undefined - N is the live ratio input; a change mid-period reshapes the
//               current period and the counter wraps if it is already past
//               the new end value.
module clk_div_int #(
  parameter int RATIO_WD = 8
) (
  input  logic          ref_clk,
  input  logic          rst,
  clk_div_int_if.slave  bus
);

  localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);
  localparam logic [RATIO_WD-1:0] TWO = RATIO_WD'(2);

  logic [RATIO_WD-1:0] cnt;
  logic [RATIO_WD-1:0] cnt_nxt;
  logic [RATIO_WD-1:0] ratio_n;
  logic [RATIO_WD-1:0] ratio_last;
  logic [RATIO_WD-1:0] half;
  logic                bypass;
  logic                div_q;
  logic                tick_q;
  logic                div_nxt;
  logic                tick_nxt;

`ifdef CLKDIV_RATIO_SHADOW_EN
  logic [RATIO_WD-1:0] ratio_shadow;

  // Shadow ratio: follows the input in bypass, otherwise only reloads at the
  // edge that closes a period, so a running period is never truncated.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      ratio_shadow <= '0;
    end else if (bypass || (cnt_nxt == '0)) begin
      ratio_shadow <= bus.div_ratio;
    end
  end

  assign ratio_n = ratio_shadow;
`else
  assign ratio_n = bus.div_ratio;
`endif

  // Ratio decode and next-count: the >= compare keeps the counter in range
  // when the ratio shrinks below the current count. The high phase covers
  // counts 1..H so the rise coincides with the count-1 period tick.
  always_comb begin
    bypass     = 1'b0;
    ratio_last = '0;
    half       = '0;
    cnt_nxt    = '0;
    div_nxt    = 1'b0;
    tick_nxt   = 1'b0;

    bypass     = !bus.clk_en || (ratio_n < TWO);
    ratio_last = ratio_n - ONE;
    half       = ratio_n >> 1;
    cnt_nxt    = (cnt >= ratio_last) ? '0 : (cnt + ONE);
    div_nxt    = (cnt_nxt != '0) && (cnt_nxt <= half);
    tick_nxt   = (cnt_nxt == ONE);
  end

  // Counter, divided-clock and tick registers; reset wins over everything,
  // bypass clears state so the first active edge always starts a fresh
  // period with the output high.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (bypass) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      div_q  <= div_nxt;
      tick_q <= tick_nxt;
    end
  end

  assign bus.div_clk     = bypass ? ref_clk : div_q;
  assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_int.sv
// tb_clk_div_int: self-checking bench for clk_div_int.
// Expected divided-clock / tick values are derived from the period pattern
// (high for the first N>>1 cycles of each N-cycle period, tick on the first)
// and queued when stimulus is applied, then popped and compared after each
// rising edge. Honours CLKDIV_RATIO_SHADOW_EN for the ratio-change scenario.
module tb_clk_div_int;

  localparam int RATIO_WD = 8;

  typedef struct packed {
    logic div_clk;
    logic tick;
  } exp_t;

  logic ref_clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  clk_div_int_if #(.RATIO_WD(RATIO_WD)) bus ();

  clk_div_int #(.RATIO_WD(RATIO_WD)) dut (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 ref_clk = ~ref_clk;

  // Expected output for the k-th active edge of a period-n run.
  function automatic exp_t model(input int k, input int n);
    exp_t e;
    e.div_clk = ((k % n) < (n / 2));
    e.tick    = ((k % n) == 0);
    return e;
  endfunction

  task automatic test_reset();
    @(negedge ref_clk);
    rst           = 1'b1;
    bus.clk_en    = 1'b0;
    bus.div_ratio = '0;
    repeat (2) @(posedge ref_clk);
    #1;
    vectors++;
    if (bus.div_clk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_bypass_high: div_clk got %b want 1", bus.div_clk);
    end
    vectors++;
    if (bus.period_tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tick: tick got %b want 0", bus.period_tick);
    end
    @(negedge ref_clk);
    #1;
    vectors++;
    if (bus.div_clk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_bypass_low: div_clk got %b want 0", bus.div_clk);
    end
    bus.clk_en    = 1'b1;
    bus.div_ratio = 8'd4;
    @(posedge ref_clk);
    #1;
    vectors++;
`ifdef CLKDIV_RATIO_SHADOW_EN
    if (bus.div_clk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_enabled: div_clk got %b want 1", bus.div_clk);
    end
`else
    if (bus.div_clk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_enabled: div_clk got %b want 0", bus.div_clk);
    end
`endif
    vectors++;
    if (bus.period_tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_enabled_tick: tick got %b want 0", bus.period_tick);
    end
    @(negedge ref_clk);
    rst           = 1'b0;
    bus.clk_en    = 1'b0;
    bus.div_ratio = '0;
  endtask

  task automatic test_ratio(input int n, input int cycles);
    exp_t e;
    @(negedge ref_clk);
    bus.clk_en    = 1'b0;
    bus.div_ratio = RATIO_WD'(n);
    @(negedge ref_clk);
    bus.clk_en = 1'b1;
    for (int k = 0; k < cycles; k++) sb.push_back(model(k, n));
    for (int k = 0; k < cycles; k++) begin
      @(posedge ref_clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (bus.div_clk !== e.div_clk) begin
        miscompares++;
        $display("[TB] FAIL ratio%0d_div k=%0d: got %b want %b", n, k, bus.div_clk, e.div_clk);
      end
      vectors++;
      if (bus.period_tick !== e.tick) begin
        miscompares++;
        $display("[TB] FAIL ratio%0d_tick k=%0d: got %b want %b", n, k, bus.period_tick, e.tick);
      end
    end
  endtask

  task automatic test_bypass();
    logic       en_tab [3];
    logic [7:0] ratio_tab [3];
    en_tab[0] = 1'b0; ratio_tab[0] = 8'd4;
    en_tab[1] = 1'b1; ratio_tab[1] = 8'd0;
    en_tab[2] = 1'b1; ratio_tab[2] = 8'd1;
    for (int t = 0; t < 3; t++) begin
      @(negedge ref_clk);
      bus.clk_en    = en_tab[t];
      bus.div_ratio = ratio_tab[t];
      for (int c = 0; c < 3; c++) begin
        @(posedge ref_clk);
        #1;
        vectors++;
        if (bus.div_clk !== ref_clk) begin
          miscompares++;
          $display("[TB] FAIL bypass%0d_high c=%0d: got %b want %b", t, c, bus.div_clk, ref_clk);
        end
        vectors++;
        if (bus.period_tick !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bypass%0d_tick c=%0d: got %b want 0", t, c, bus.period_tick);
        end
        @(negedge ref_clk);
        #1;
        vectors++;
        if (bus.div_clk !== ref_clk) begin
          miscompares++;
          $display("[TB] FAIL bypass%0d_low c=%0d: got %b want %b", t, c, bus.div_clk, ref_clk);
        end
      end
    end
  endtask

  task automatic test_ratio_change();
    exp_t e;
    int   total;
    @(negedge ref_clk);
    bus.clk_en    = 1'b0;
    bus.div_ratio = 8'd8;
    @(negedge ref_clk);
    bus.clk_en = 1'b1;
    for (int k = 0; k < 5; k++) sb.push_back(model(k, 8));
    for (int k = 0; k < 5; k++) begin
      @(posedge ref_clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.div_clk, bus.period_tick} !== {e.div_clk, e.tick}) begin
        miscompares++;
        $display("[TB] FAIL change_pre k=%0d: div/tick got %b%b want %b%b", k, bus.div_clk, bus.period_tick, e.div_clk, e.tick);
      end
    end
    @(negedge ref_clk);
    bus.div_ratio = 8'd2;
`ifdef CLKDIV_RATIO_SHADOW_EN
    sb.push_back('{1'b0, 1'b0});
    sb.push_back('{1'b0, 1'b0});
    sb.push_back('{1'b0, 1'b0});
    sb.push_back('{1'b1, 1'b1});
    sb.push_back('{1'b0, 1'b0});
    sb.push_back('{1'b1, 1'b1});
`else
    sb.push_back('{1'b0, 1'b0});
    sb.push_back('{1'b1, 1'b1});
    sb.push_back('{1'b0, 1'b0});
    sb.push_back('{1'b1, 1'b1});
    sb.push_back('{1'b0, 1'b0});
`endif
    total = sb.size();
    for (int k = 0; k < total; k++) begin
      @(posedge ref_clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.div_clk, bus.period_tick} !== {e.div_clk, e.tick}) begin
        miscompares++;
        $display("[TB] FAIL change_post k=%0d: div/tick got %b%b want %b%b", k, bus.div_clk, bus.period_tick, e.div_clk, e.tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge ref_clk);
    bus.clk_en    = 1'b0;
    bus.div_ratio = 8'd6;
    @(negedge ref_clk);
    bus.clk_en = 1'b1;
    repeat (2) @(posedge ref_clk);
    #1;
    vectors++;
    if (bus.div_clk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: div_clk got %b want 1", bus.div_clk);
    end
    @(negedge ref_clk);
    rst = 1'b1;
    @(negedge ref_clk);
    #1;
    vectors++;
    if ({bus.div_clk, bus.period_tick} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rstmid_clear: div/tick got %b%b want 00", bus.div_clk, bus.period_tick);
    end
    rst = 1'b0;
`ifdef CLKDIV_RATIO_SHADOW_EN
    @(posedge ref_clk);
    #1;
    vectors++;
    if (bus.period_tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_reload_tick: got %b want 0", bus.period_tick);
    end
    @(negedge ref_clk);
`endif
    for (int k = 0; k < 12; k++) sb.push_back(model(k, 6));
    for (int k = 0; k < 12; k++) begin
      @(posedge ref_clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.div_clk, bus.period_tick} !== {e.div_clk, e.tick}) begin
        miscompares++;
        $display("[TB] FAIL rstmid_restart k=%0d: div/tick got %b%b want %b%b", k, bus.div_clk, bus.period_tick, e.div_clk, e.tick);
      end
    end
  endtask

  task automatic test_enable_toggle();
    exp_t e;
    @(negedge ref_clk);
    bus.clk_en    = 1'b0;
    bus.div_ratio = 8'd4;
    @(negedge ref_clk);
    bus.clk_en = 1'b1;
    repeat (2) @(posedge ref_clk);
    #1;
    vectors++;
    if ({bus.div_clk, bus.period_tick} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL entog_pre: div/tick got %b%b want 10", bus.div_clk, bus.period_tick);
    end
    @(negedge ref_clk);
    bus.clk_en = 1'b0;
    #1;
    vectors++;
    if (bus.div_clk !== ref_clk) begin
      miscompares++;
      $display("[TB] FAIL entog_immediate: div_clk got %b want %b", bus.div_clk, ref_clk);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge ref_clk);
      #1;
      vectors++;
      if ({bus.div_clk, bus.period_tick} !== {ref_clk, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL entog_bypass c=%0d: div/tick got %b%b want %b0", c, bus.div_clk, bus.period_tick, ref_clk);
      end
    end
    @(negedge ref_clk);
    bus.clk_en = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back(model(k, 4));
    for (int k = 0; k < 8; k++) begin
      @(posedge ref_clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.div_clk, bus.period_tick} !== {e.div_clk, e.tick}) begin
        miscompares++;
        $display("[TB] FAIL entog_resume k=%0d: div/tick got %b%b want %b%b", k, bus.div_clk, bus.period_tick, e.div_clk, e.tick);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.clk_en    = 1'b0;
    bus.div_ratio = '0;
    $display("[TB] starting clk_div_int bench");
    test_reset();
    test_ratio(4, 12);
    test_ratio(5, 15);
    test_ratio(3, 9);
    test_ratio(2, 8);
    test_bypass();
    test_ratio_change();
    test_reset_mid();
    test_enable_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
